// File: rtl/wb_regfile_if.sv
// Pipeline-side bundle for the Y86-64 writeback stage: the W-stage inputs, the
// decode read ports and the W-stage forwarding outputs.
interface wb_regfile_if #(
   parameter int DATA_W = 64
);
   logic [2:0]        w_stat;
   logic [3:0]        w_icode;
   logic [3:0]        w_rA;
   logic [3:0]        w_rB;
   logic              w_cnd;
   logic [DATA_W-1:0] w_valE;
   logic [DATA_W-1:0] w_valM;
   logic [3:0]        d_srcA;
   logic [3:0]        d_srcB;
   logic [DATA_W-1:0] d_rvalA;
   logic [DATA_W-1:0] d_rvalB;
   logic [3:0]        wb_dstE;
   logic [3:0]        wb_dstM;
   logic [DATA_W-1:0] wb_valE;
   logic [DATA_W-1:0] wb_valM;

   modport master (
      output w_stat, w_icode, w_rA, w_rB, w_cnd, w_valE, w_valM, d_srcA, d_srcB,
      input  d_rvalA, d_rvalB, wb_dstE, wb_dstM, wb_valE, wb_valM
   );

   modport slave (
      input  w_stat, w_icode, w_rA, w_rB, w_cnd, w_valE, w_valM, d_srcA, d_srcB,
      output d_rvalA, d_rvalB, wb_dstE, wb_dstM, wb_valE, wb_valM
   );
endinterface

// File: rtl/wb_regfile.sv
// Y86-64 writeback stage: destination decode, 15 x DATA_W register file with two
// decode read ports, RUN/HALTED status machine and retired-instruction counter.
module wb_regfile #(
   parameter int                DATA_W   = 64,
   parameter logic [DATA_W-1:0] INIT_RSP = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   wb_regfile_if.slave       bus,
   output logic [2:0]        cpu_stat,
   output logic              halted,
   output logic [63:0]       retired,
   input  logic [3:0]        dbg_sel,
   output logic [DATA_W-1:0] dbg_val
);
   localparam logic [3:0] RNONE = 4'hF;
   localparam logic [3:0] RSP   = 4'h4;
   localparam logic [2:0] S_AOK = 3'd1;
   localparam logic [2:0] S_INS = 3'd4;

   typedef enum logic {ST_RUN, ST_HALTED} state_t;

   state_t            state, state_nxt;
   logic [2:0]        stat_n;
   logic [3:0]        dst_e, dst_m;
   logic              commit_ok;
   logic [DATA_W-1:0] regs [0:14];

   // Out-of-range status codes are folded into INS.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      stat_n = bus.w_stat;
      if (bus.w_stat == 3'd0 || bus.w_stat > S_INS) stat_n = S_INS;
   end

   always_comb begin
      dst_e = RNONE;
      dst_m = RNONE;
      unique case (bus.w_icode)
         4'h2:                      dst_e = bus.w_cnd ? bus.w_rB : RNONE;
         4'h3, 4'h6:                dst_e = bus.w_rB;
         4'h8, 4'h9, 4'hA, 4'hB:    dst_e = RSP;
         default:                   dst_e = RNONE;
      endcase
      if (bus.w_icode == 4'h5 || bus.w_icode == 4'hB) dst_m = bus.w_rA;
   end

   assign commit_ok   = (state == ST_RUN) && (stat_n == S_AOK);
   assign bus.wb_dstE = commit_ok ? dst_e : RNONE;
   assign bus.wb_dstM = commit_ok ? dst_m : RNONE;
   assign bus.wb_valE = bus.w_valE;
   assign bus.wb_valM = bus.w_valM;
   assign halted      = (state == ST_HALTED);

   always_comb begin
      state_nxt = state;
      if (state == ST_RUN && stat_n != S_AOK) state_nxt = ST_HALTED;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_RUN;
         cpu_stat <= S_AOK;
         retired  <= '0;
      end else begin
         state <= state_nxt;
         if (state == ST_RUN) cpu_stat <= stat_n;
         if (commit_ok && bus.w_icode != 4'h1) retired <= retired + 64'd1;
      end
   end

   // NOTE: the architectural registers need a defined reset value, so the array is reset explicitly.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 15; i++) regs[i] <= (i == 4) ? INIT_RSP : '0;
      end else begin
         if (bus.wb_dstE != RNONE) regs[bus.wb_dstE] <= bus.w_valE;
         // M port is written last so it wins when both ports target the same register.
         if (bus.wb_dstM != RNONE) regs[bus.wb_dstM] <= bus.w_valM;
      end
   end

   // Reads return the pre-edge contents; decode forwards same-cycle results itself.
   assign bus.d_rvalA = (bus.d_srcA == RNONE) ? '0 : regs[bus.d_srcA];
   assign bus.d_rvalB = (bus.d_srcB == RNONE) ? '0 : regs[bus.d_srcB];
   assign dbg_val     = (dbg_sel == RNONE)    ? '0 : regs[dbg_sel];
endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: reset, commits, popq priority, cmov, bubbles,
// halt/fault freezing and reset out of HALTED.
module tb_wb_regfile;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  cpu_stat;
   logic        halted;
   logic [63:0] retired;
   logic [3:0]  dbg_sel;
   logic [63:0] dbg_val;
   int          checks   = 0;
   int          failures = 0;

   wb_regfile_if #(.DATA_W(64)) bus ();

   wb_regfile #(.DATA_W(64), .INIT_RSP(64'h100)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .cpu_stat (cpu_stat),
      .halted   (halted),
      .retired  (retired),
      .dbg_sel  (dbg_sel),
      .dbg_val  (dbg_val)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] st, input logic [3:0] ic, input logic [3:0] ra,
                        input logic [3:0] rb, input logic cnd,
                        input logic [63:0] ve, input logic [63:0] vm);
      bus.w_stat  = st;
      bus.w_icode = ic;
      bus.w_rA    = ra;
      bus.w_rB    = rb;
      bus.w_cnd   = cnd;
      bus.w_valE  = ve;
      bus.w_valM  = vm;
   endtask

   task automatic bubble();
      drive(3'd1, 4'h1, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0);
      #1;
   endtask

   task automatic rd(input logic [3:0] sel, output logic [63:0] v);
      dbg_sel = sel;
      #1;
      v = dbg_val;
   endtask

   logic [63:0] v;

   initial begin
      rst_n      = 1'b0;
      bus.d_srcA = 4'h4;
      bus.d_srcB = 4'h0;
      dbg_sel    = 4'h0;
      drive(3'd1, 4'h1, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0);
      step();
      step();
      rst_n = 1'b1;
      #1;

      // Reset state
      check("rst_rsp_portA", bus.d_rvalA, 64'h100);
      check("rst_reg0_portB", bus.d_rvalB, 64'h0);
      for (int i = 0; i < 15; i++) begin
         rd(4'(i), v);
         check($sformatf("rst_reg%0d", i), v, (i == 4) ? 64'h100 : 64'h0);
      end
      check("rst_cpu_stat", 64'(cpu_stat), 64'd1);
      check("rst_halted", 64'(halted), 64'd0);
      check("rst_retired", retired, 64'd0);

      // irmovq $0x1234, %rdx
      bus.d_srcA = 4'h2;
      drive(3'd1, 4'h3, 4'hF, 4'h2, 1'b0, 64'h1234, 64'h0);
      #1;
      check("irmov_same_cycle_read", bus.d_rvalA, 64'h0);
      check("irmov_dstE", 64'(bus.wb_dstE), 64'h2);
      check("irmov_dstM", 64'(bus.wb_dstM), 64'hF);
      check("irmov_valE_pass", bus.wb_valE, 64'h1234);
      step();
      bubble();
      check("irmov_reg2", bus.d_rvalA, 64'h1234);
      check("irmov_retired", retired, 64'd1);

      // popq %rsp: both ports target reg 4, M wins
      drive(3'd1, 4'hB, 4'h4, 4'hF, 1'b0, 64'h108, 64'hDEAD);
      #1;
      check("popq_dstE", 64'(bus.wb_dstE), 64'h4);
      check("popq_dstM", 64'(bus.wb_dstM), 64'h4);
      check("popq_valM_pass", bus.wb_valM, 64'hDEAD);
      step();
      bubble();
      rd(4'h4, v);
      check("popq_reg4", v, 64'hDEAD);
      check("popq_retired", retired, 64'd2);

      // cmov not taken, then taken
      drive(3'd1, 4'h2, 4'h1, 4'h3, 1'b0, 64'h55, 64'h0);
      #1;
      check("cmov0_dstE", 64'(bus.wb_dstE), 64'hF);
      step();
      bubble();
      rd(4'h3, v);
      check("cmov0_reg3", v, 64'h0);
      check("cmov0_retired", retired, 64'd3);
      drive(3'd1, 4'h2, 4'h1, 4'h3, 1'b1, 64'h77, 64'h0);
      step();
      bubble();
      rd(4'h3, v);
      check("cmov1_reg3", v, 64'h77);
      check("cmov1_retired", retired, 64'd4);

      // mrmovq to reg 8 through the M port
      drive(3'd1, 4'h5, 4'h8, 4'h1, 1'b0, 64'h40, 64'hBEEF);
      step();
      bubble();
      rd(4'h8, v);
      check("mrmov_reg8", v, 64'hBEEF);
      check("mrmov_retired", retired, 64'd5);

      // Five bubbles: nothing retires, selector F reads zero
      for (int i = 0; i < 5; i++) step();
      check("bubble_retired", retired, 64'd5);
      bus.d_srcA = 4'hF;
      rd(4'hF, v);
      check("srcA_F_zero", bus.d_rvalA, 64'h0);
      check("dbg_F_zero", v, 64'h0);

      // Halt with an instruction that would otherwise write reg 5
      drive(3'd2, 4'h3, 4'hF, 4'h5, 1'b0, 64'h7, 64'h0);
      #1;
      check("halt_dstE_forced", 64'(bus.wb_dstE), 64'hF);
      check("halt_halted_pre", 64'(halted), 64'd0);
      step();
      bubble();
      rd(4'h5, v);
      check("halt_reg5", v, 64'h0);
      check("halt_cpu_stat", 64'(cpu_stat), 64'd2);
      check("halt_halted", 64'(halted), 64'd1);
      check("halt_retired", retired, 64'd5);

      // AOK irmovq after halt is ignored
      drive(3'd1, 4'h3, 4'hF, 4'h6, 1'b0, 64'h9, 64'h0);
      #1;
      check("halted_dstE_forced", 64'(bus.wb_dstE), 64'hF);
      step();
      bubble();
      rd(4'h6, v);
      check("halted_reg6", v, 64'h0);
      check("halted_retired", retired, 64'd5);
      check("halted_cpu_stat", 64'(cpu_stat), 64'd2);

      // Reset out of HALTED
      rst_n = 1'b0;
      drive(3'd1, 4'h3, 4'hF, 4'h9, 1'b0, 64'h99, 64'h0);
      step();
      rst_n = 1'b1;
      bubble();
      rd(4'h9, v);
      check("rst2_no_write_reg9", v, 64'h0);
      rd(4'h2, v);
      check("rst2_reg2", v, 64'h0);
      rd(4'h4, v);
      check("rst2_reg4", v, 64'h100);
      check("rst2_cpu_stat", 64'(cpu_stat), 64'd1);
      check("rst2_halted", 64'(halted), 64'd0);
      check("rst2_retired", retired, 64'd0);

      // ADR then INS: first fault sticks
      drive(3'd3, 4'h3, 4'hF, 4'h7, 1'b0, 64'h11, 64'h0);
      step();
      drive(3'd4, 4'h3, 4'hF, 4'h7, 1'b0, 64'h22, 64'h0);
      step();
      bubble();
      rd(4'h7, v);
      check("adr_reg7", v, 64'h0);
      check("adr_cpu_stat", 64'(cpu_stat), 64'd3);
      check("adr_halted", 64'(halted), 64'd1);
      check("adr_retired", retired, 64'd0);

      // Out-of-range status is treated as INS
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      drive(3'd0, 4'h3, 4'hF, 4'h1, 1'b0, 64'h33, 64'h0);
      step();
      bubble();
      rd(4'h1, v);
      check("bad_stat_reg1", v, 64'h0);
      check("bad_stat_cpu_stat", 64'(cpu_stat), 64'd4);
      check("bad_stat_halted", 64'(halted), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
